// File: rtl/hrm_slink_rxbuf_pkg.sv
// Shared definitions for the slink receive buffer: link word layout,
// drop counter width and the receive FSM encoding.
package hrm_slink_rxbuf_pkg;

  localparam int unsigned HRM_WORD_W  = 18;
  localparam int unsigned HRM_SOP_BIT = 17;
  localparam int unsigned HRM_EOP_BIT = 16;
  localparam int unsigned DROP_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } rx_state_e;

endpackage

// File: rtl/hrm_rxbuf_dpram.sv
// Simple dual-port RAM, 2^AW x HRM_WORD_W: synchronous write, registered read.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (read register only)
//   we/waddr/wdata  write port
//   re/raddr     read enable and address
//   rdata        registered read word, holds its value when re=0
module hrm_rxbuf_dpram
  import hrm_slink_rxbuf_pkg::*;
#(
  parameter int unsigned AW = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [HRM_WORD_W-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [HRM_WORD_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [HRM_WORD_W-1:0] mem [DEPTH];

  // Storage array carries no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register doubles as the downstream data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/hrm_slink_rxbuf.sv
// Packet store-and-forward receive buffer between the slink deframer and the
// MM RX path. Only complete, CRC-good packets become readable; anything else
// is rewound to the last commit point and counted.
// Ports:
//   clk_100m, rst_100m   clock, asynchronous active-high reset
//   rx_dval/rx_data      deframer words ([17]=SOP, [16]=EOP)
//   rx_crc_ok            CRC verdict, meaningful with an EOP word
//   mm_slink_rdreq       pull request from MM RX
//   slink_mm_empty       no committed word left
//   slink_mm_dval/data   read word, one cycle after an accepted request
//   rx_drop_cnt          saturating dropped-packet count
//   rx_ovf_err           pulse: packet dropped because the buffer was full
//   rx_fmt_err           pulse: framing violation
module hrm_slink_rxbuf
  import hrm_slink_rxbuf_pkg::*;
#(
  parameter int unsigned AW          = 9,
  parameter int unsigned MAX_PKT_LEN = 256
) (
  input  logic                  clk_100m,
  input  logic                  rst_100m,
  input  logic                  rx_dval,
  input  logic [HRM_WORD_W-1:0] rx_data,
  input  logic                  rx_crc_ok,
  input  logic                  mm_slink_rdreq,
  output logic                  slink_mm_empty,
  output logic                  slink_mm_dval,
  output logic [HRM_WORD_W-1:0] slink_mm_data,
  output logic [DROP_CNT_W-1:0] rx_drop_cnt,
  output logic                  rx_ovf_err,
  output logic                  rx_fmt_err
);

  localparam int unsigned PW  = AW + 1;
  localparam int unsigned CW1 = DROP_CNT_W + 1;
  localparam logic [PW-1:0] DEPTH = PW'(2 ** AW);

  rx_state_e       state_q, state_d;
  logic [PW-1:0]   wr_q, wr_d, cmt_q, cmt_d, rd_q, rd_d, base;
  logic [PW-1:0]   used, pkt_len, cmt_used;
  logic            full, base_full, too_long;
  logic            sop, eop;
  logic            we, start_pkt, do_write, ovf_d, fmt_d;
  logic [AW-1:0]   wa;
  logic [1:0]      drop_inc;
  logic [CW1-1:0]  drop_sum;
  logic            rd_acc, empty_d;

  assign sop       = rx_data[HRM_SOP_BIT];
  assign eop       = rx_data[HRM_EOP_BIT];
  assign used      = wr_q - rd_q;
  assign cmt_used  = cmt_q - rd_q;
  assign pkt_len   = wr_q - cmt_q;
  assign full      = (used == DEPTH);
  // A new packet starts at cmt_ptr, so its room is judged after rewind.
  assign base_full = (cmt_used == DEPTH);
  assign too_long  = (32'(pkt_len) >= MAX_PKT_LEN);

  // State register and write-side pointers.
  always_ff @(posedge clk_100m or posedge rst_100m) begin
    if (rst_100m) begin
      state_q    <= ST_IDLE;
      wr_q       <= '0;
      cmt_q      <= '0;
      rx_ovf_err <= 1'b0;
      rx_fmt_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      cmt_q      <= cmt_d;
      rx_ovf_err <= ovf_d;
      rx_fmt_err <= fmt_d;
    end
  end

  // Receive FSM: next state, write strobe, pointer updates, error pulses.
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    cmt_d     = cmt_q;
    base      = wr_q;
    we        = 1'b0;
    wa        = '0;
    drop_inc  = 2'd0;
    ovf_d     = 1'b0;
    fmt_d     = 1'b0;
    start_pkt = 1'b0;
    do_write  = 1'b0;
    if (rx_dval) begin
      case (state_q)
        ST_RECV: begin
          if (sop) begin
            fmt_d     = 1'b1;
            drop_inc  = drop_inc + 2'd1;
            wr_d      = cmt_q;
            start_pkt = 1'b1;
          end else if (full || too_long) begin
            wr_d     = cmt_q;
            drop_inc = drop_inc + 2'd1;
            ovf_d    = full;
            state_d  = eop ? ST_IDLE : ST_DROP;
          end else begin
            do_write = 1'b1;
          end
        end
        ST_DROP: begin
          if (sop) begin
            start_pkt = 1'b1;
          end else if (eop) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          if (sop) begin
            start_pkt = 1'b1;
          end else begin
            fmt_d = 1'b1;
          end
        end
      endcase

      // A SOP that finds no room after rewind is dropped as an overflow.
      if (start_pkt) begin
        base = cmt_q;
        if (base_full) begin
          drop_inc = drop_inc + 2'd1;
          ovf_d    = 1'b1;
          wr_d     = cmt_q;
          state_d  = eop ? ST_IDLE : ST_DROP;
        end else begin
          do_write = 1'b1;
          state_d  = ST_RECV;
        end
      end

      // EOP either publishes the packet or rewinds it.
      if (do_write) begin
        we   = 1'b1;
        wa   = base[AW-1:0];
        wr_d = base + PW'(1);
        if (eop) begin
          state_d = ST_IDLE;
          if (rx_crc_ok) begin
            cmt_d = base + PW'(1);
          end else begin
            wr_d     = cmt_q;
            drop_inc = drop_inc + 2'd1;
          end
        end
      end
    end
  end

  // Saturating drop counter.
  assign drop_sum = {1'b0, rx_drop_cnt} + CW1'(drop_inc);

  always_ff @(posedge clk_100m or posedge rst_100m) begin
    if (rst_100m) begin
      rx_drop_cnt <= '0;
    end else if (drop_sum[DROP_CNT_W]) begin
      rx_drop_cnt <= '1;
    end else begin
      rx_drop_cnt <= drop_sum[DROP_CNT_W-1:0];
    end
  end

  // Read side: empty looks at next-cycle pointers so a same-cycle commit
  // and read are both reflected.
  assign rd_acc  = mm_slink_rdreq & ~slink_mm_empty;
  assign rd_d    = rd_q + PW'(rd_acc);
  assign empty_d = (rd_d == cmt_d);

  always_ff @(posedge clk_100m or posedge rst_100m) begin
    if (rst_100m) begin
      rd_q           <= '0;
      slink_mm_empty <= 1'b1;
      slink_mm_dval  <= 1'b0;
    end else begin
      rd_q           <= rd_d;
      slink_mm_empty <= empty_d;
      slink_mm_dval  <= rd_acc;
    end
  end

  hrm_rxbuf_dpram #(
    .AW (AW)
  ) u_ram (
    .clk   (clk_100m),
    .rst   (rst_100m),
    .we    (we),
    .waddr (wa),
    .wdata (rx_data),
    .re    (rd_acc),
    .raddr (rd_q[AW-1:0]),
    .rdata (slink_mm_data)
  );

endmodule

// File: tb/tb_hrm_slink_rxbuf.sv
// Directed bench for hrm_slink_rxbuf. Instance a: AW=4, MAX_PKT_LEN=16.
// Instance b: AW=4, MAX_PKT_LEN=8 (used for the oversize case). Both share
// the input stimulus.
module tb_hrm_slink_rxbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_dval;
  logic [17:0] rx_data;
  logic        rx_crc_ok;
  logic        rdreq;

  logic        a_empty, a_dval, a_ovf, a_fmt;
  logic [17:0] a_data;
  logic [15:0] a_drop;
  logic        b_empty, b_dval, b_ovf, b_fmt;
  logic [17:0] b_data;
  logic [15:0] b_drop;

  int n_vec = 0;
  int n_err = 0;

  logic [17:0] eq[$];
  logic [19:0] stim[$];
  logic [17:0] pend[$];
  logic [17:0] mq[$];

  always #5 clk = ~clk;

  hrm_slink_rxbuf #(.AW(4), .MAX_PKT_LEN(16)) u_dut_a (
    .clk_100m       (clk),
    .rst_100m       (rst),
    .rx_dval        (rx_dval),
    .rx_data        (rx_data),
    .rx_crc_ok      (rx_crc_ok),
    .mm_slink_rdreq (rdreq),
    .slink_mm_empty (a_empty),
    .slink_mm_dval  (a_dval),
    .slink_mm_data  (a_data),
    .rx_drop_cnt    (a_drop),
    .rx_ovf_err     (a_ovf),
    .rx_fmt_err     (a_fmt)
  );

  hrm_slink_rxbuf #(.AW(4), .MAX_PKT_LEN(8)) u_dut_b (
    .clk_100m       (clk),
    .rst_100m       (rst),
    .rx_dval        (rx_dval),
    .rx_data        (rx_data),
    .rx_crc_ok      (rx_crc_ok),
    .mm_slink_rdreq (rdreq),
    .slink_mm_empty (b_empty),
    .slink_mm_dval  (b_dval),
    .slink_mm_data  (b_data),
    .rx_drop_cnt    (b_drop),
    .rx_ovf_err     (b_ovf),
    .rx_fmt_err     (b_fmt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] mkw(input logic s, input logic e, input logic [15:0] p);
    return {s, e, p};
  endfunction

  task automatic do_reset();
    rx_dval   = 1'b0;
    rx_data   = '0;
    rx_crc_ok = 1'b0;
    rdreq     = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One word presented for one clock; returns at the following negedge.
  task automatic put(input logic [17:0] d, input logic crc);
    rx_dval   = 1'b1;
    rx_data   = d;
    rx_crc_ok = crc;
    @(negedge clk);
    rx_dval   = 1'b0;
    rx_crc_ok = 1'b0;
  endtask

  // Back-to-back reads from instance a, compared against eq.
  task automatic drain_a(input string tag);
    int n;
    n = eq.size();
    rdreq = 1'b1;
    for (int i = 0; i < n; i++) begin
      logic [17:0] e;
      e = eq.pop_front();
      @(negedge clk);
      if (i == n - 1) rdreq = 1'b0;
      chk({tag, "_dval"}, 32'(a_dval), 32'd1);
      chk({tag, "_data"}, 32'(a_data), 32'(e));
    end
    rdreq = 1'b0;
    chk({tag, "_empty_after"}, 32'(a_empty), 32'd1);
  endtask

  initial begin
    rst = 1'b0; rx_dval = 1'b0; rx_data = '0; rx_crc_ok = 1'b0; rdreq = 1'b0;
    #2;
    rst = 1'b1;
    @(negedge clk);
    // Reset values
    chk("rst_empty", 32'(a_empty), 32'd1);
    chk("rst_dval",  32'(a_dval),  32'd0);
    chk("rst_data",  32'(a_data),  32'd0);
    chk("rst_drop",  32'(a_drop),  32'd0);
    chk("rst_ovf",   32'(a_ovf),   32'd0);
    chk("rst_fmt",   32'(a_fmt),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single good packet
    put(18'h20001, 1'b1);
    put(18'h00002, 1'b1);
    chk("single_empty_pre_eop", 32'(a_empty), 32'd1);
    put(18'h10003, 1'b1);
    chk("single_empty_post_eop", 32'(a_empty), 32'd0);
    eq = '{18'h20001, 18'h00002, 18'h10003};
    drain_a("single");
    rdreq = 1'b1;
    @(negedge clk);
    rdreq = 1'b0;
    chk("rd_on_empty_dval", 32'(a_dval), 32'd0);
    chk("rd_on_empty_empty", 32'(a_empty), 32'd1);

    // CRC failure followed by a good packet
    do_reset();
    put(18'h20001, 1'b1);
    put(18'h00002, 1'b1);
    put(18'h10003, 1'b0);
    chk("crc_empty", 32'(a_empty), 32'd1);
    chk("crc_drop",  32'(a_drop),  32'd1);
    put(18'h20011, 1'b1);
    put(18'h10012, 1'b1);
    chk("crc_next_empty", 32'(a_empty), 32'd0);
    eq = '{18'h20011, 18'h10012};
    drain_a("crc_next");

    // Framing violations
    do_reset();
    put(18'h00055, 1'b1);
    chk("fmt_idle_pulse", 32'(a_fmt), 32'd1);
    chk("fmt_idle_empty", 32'(a_empty), 32'd1);
    @(negedge clk);
    chk("fmt_pulse_end", 32'(a_fmt), 32'd0);
    put(18'h20021, 1'b1);
    put(18'h20022, 1'b1);
    chk("fmt_sopsop_pulse", 32'(a_fmt), 32'd1);
    chk("fmt_sopsop_drop",  32'(a_drop), 32'd1);
    put(18'h10023, 1'b1);
    chk("fmt_sopsop_empty", 32'(a_empty), 32'd0);
    eq = '{18'h20022, 18'h10023};
    drain_a("fmt_pkt2");

    // Overflow on a 16-word buffer
    do_reset();
    for (int j = 0; j < 10; j++) put(mkw(j == 0, j == 9, 16'(16'h0100 + j)), 1'b1);
    chk("ovf_first_commit", 32'(a_empty), 32'd0);
    for (int j = 0; j < 10; j++) begin
      put(mkw(j == 0, j == 9, 16'(16'h0200 + j)), 1'b1);
      chk($sformatf("ovf_pulse_w%0d", j + 1), 32'(a_ovf), 32'(j == 6));
    end
    chk("ovf_drop", 32'(a_drop), 32'd1);
    for (int j = 0; j < 10; j++) eq.push_back(mkw(j == 0, j == 9, 16'(16'h0100 + j)));
    drain_a("ovf_first_pkt");

    // Oversize on the MAX_PKT_LEN=8 instance
    do_reset();
    for (int j = 0; j < 9; j++) put(mkw(j == 0, j == 8, 16'(16'h0300 + j)), 1'b1);
    chk("big_ovf",   32'(b_ovf),   32'd0);
    chk("big_drop",  32'(b_drop),  32'd1);
    chk("big_empty", 32'(b_empty), 32'd1);
    for (int j = 0; j < 8; j++) put(mkw(j == 0, j == 7, 16'(16'h0400 + j)), 1'b1);
    chk("max_empty", 32'(b_empty), 32'd0);
    chk("max_drop",  32'(b_drop),  32'd1);
    rdreq = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j == 7) rdreq = 1'b0;
      chk("max_dval", 32'(b_dval), 32'd1);
      chk("max_data", 32'(b_data), 32'(mkw(j == 0, j == 7, 16'(16'h0400 + j))));
    end
    chk("max_empty_after", 32'(b_empty), 32'd1);

    // Reset mid-packet: partial packet lost, not counted
    do_reset();
    put(18'h20500, 1'b1);
    put(18'h00501, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_drop",  32'(a_drop),  32'd0);
    chk("midrst_empty", 32'(a_empty), 32'd1);
    put(18'h10502, 1'b1);
    chk("midrst_eop_fmt", 32'(a_fmt), 32'd1);
    chk("midrst_eop_empty", 32'(a_empty), 32'd1);

    // Concurrency: continuous rdreq across pointer wrap, 40 packets
    do_reset();
    for (int k = 0; k < 40; k++) begin
      int len;
      logic bad;
      len = 1 + (k % 5);
      bad = ((k % 7) == 3);
      for (int j = 0; j < len; j++)
        stim.push_back({1'b1, ~bad, mkw(j == 0, j == len - 1, 16'(k * 16 + j))});
      if ((k % 3) == 0) stim.push_back(20'h0);
    end
    for (int i = 0; i < 20; i++) stim.push_back(20'h0);
    rdreq = 1'b1;
    begin
      logic prev_empty;
      prev_empty = a_empty;
      foreach (stim[c]) begin
        logic [19:0] s;
        s = stim[c];
        rx_dval   = s[19];
        rx_crc_ok = s[18];
        rx_data   = s[17:0];
        @(negedge clk);
        if (!prev_empty) begin
          logic [17:0] e;
          e = (mq.size() != 0) ? mq.pop_front() : 18'h3ffff;
          chk("conc_dval", 32'(a_dval), 32'd1);
          chk("conc_data", 32'(a_data), 32'(e));
        end else begin
          chk("conc_nodval", 32'(a_dval), 32'd0);
        end
        if (s[19]) begin
          if (s[17]) pend.delete();
          pend.push_back(s[17:0]);
          if (s[16]) begin
            if (s[18]) foreach (pend[p]) mq.push_back(pend[p]);
            pend.delete();
          end
        end
        chk("conc_empty", 32'(a_empty), 32'(mq.size() == 0));
        prev_empty = a_empty;
      end
    end
    rdreq = 1'b0;
    rx_dval = 1'b0;
    chk("conc_all_read", 32'(mq.size()), 32'd0);
    chk("conc_drop", 32'(a_drop), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
